fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage that drives inst_memory. Holds the PC, issues im_addr/en_im and
//  captures the big-endian 32-bit word returned in the same cycle. Presents {inst, pc} to
//  decode through a valid/ready output register.
//  Handles branch redirect/flush, downstream stall and end-of-program detection.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on start
//  IMEM_BYTES 32             byte size of instruction memory; last legal fetch addr = IMEM_BYTES-4
//  CNT_W      16             width of delivered-instruction counter
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   IDLE->RUN, PC<=RESET_PC
//  im_addr        out  32  byte address to inst_memory (= pc)
//  en_im          out  1   inst_memory read enable
//  im_inst        in   32  word from inst_memory, valid same cycle as en_im
//  branch_taken   in   1   redirect request from execute
//  branch_target  in   32  redirect byte address
//  id_ready       in   1   decode accepts inst_out this cycle
//  inst_valid     out  1   inst_out/pc_out hold a live instruction
//  inst_out       out  32  captured instruction
//  pc_out         out  32  address inst_out was fetched from
//  done           out  1   state==DONE
//  fetch_err      out  1   sticky: illegal redirect target
//  fetch_count    out  CNT_W  instructions handed to decode (inst_valid&&id_ready), wraps
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, inst_valid=0, inst_out=0, pc_out=0, done=0, fetch_err=0,
//   fetch_count=0, en_im=0. rst mid-operation discards any held instruction; reset wins over all.
//  FSM IDLE -> RUN on start; RUN -> DONE on end-of-program or illegal redirect; DONE exits only on rst.
//  IDLE: en_im=0, inst_valid=0; start ignored in RUN/DONE.
//  RUN: load = !inst_valid || id_ready. im_addr=pc always (combinational).
//   Normal fetch (load && pc<=IMEM_BYTES-4 && !branch_taken): en_im=1; next edge
//    inst_out<=im_inst, pc_out<=pc, inst_valid<=1, pc<=pc+4. Latency: 1 cycle addr->inst_out;
//    throughput 1 inst/cycle while id_ready=1.
//   Stall (!load): en_im=0; pc, inst_out, pc_out, inst_valid held unchanged.
//   End (load && pc>IMEM_BYTES-4 && !branch_taken): en_im=0, inst_valid<=0, state<=DONE.
//   Redirect (branch_taken): priority over stall and end. en_im=0; inst_valid<=0 (flush,
//    even if id_ready=0); pc<=branch_target.
//    If branch_target[1:0]!=0 or branch_target>IMEM_BYTES-4: fetch_err<=1, state<=DONE, pc unchanged.
//  DONE: en_im=0; branch_taken, start ignored; inst_valid already 0.
//  fetch_count increments on every inst_valid&&id_ready edge, incl. the flush cycle
//   (a handshake that completes in the same cycle as a redirect counts).
//  PC arithmetic 32-bit unsigned; pc+4 never overflows given IMEM_BYTES bound.
// STRUCTURE
//  risc_pkg: INST_W=32, ADDR_W=32, IMEM_BYTES default, fetch-state enum {IDLE,RUN,DONE}.
//  Sub-module fetch_buffer: valid/ready holding register for {inst,pc} with load/flush inputs.
//  PC register, FSM and counter stay in fetch_unit.
// TESTING (image: 0:01230000 4:14150000 8:F0B7AB1E 12:D07B0005 16:36B40000)
//  Reset/idle: rst 2 cycles, no start -> en_im=0, inst_valid=0, all outputs 0 for 5 cycles.
//  Stream: start, id_ready=1 -> 1 cycle later inst_out=01230000/pc_out=0, then 14150000/4,
//   F0B7AB1E/8 on consecutive cycles.
//  Stall: id_ready=0 while inst_out=F0B7AB1E -> held 3 cycles, en_im=0;
//   id_ready=1 -> next D07B0005/12; fetch_count counts 1 for the stalled word.
//  Redirect: branch_taken=1,target=16 while id_ready=0 -> inst_valid=0 next cycle,
//   then 36B40000/16.
//  Simultaneous: branch_taken=1 and id_ready=0 same cycle -> redirect wins;
//   target=6 -> fetch_err=1, done=1, en_im=0 thereafter.
//  End/reset: IMEM_BYTES=20, stream -> after 36B40000/16 accepted done=1;
//   rst mid-stream -> IDLE, inst_valid=0, fetch_count=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package risc_pkg;

    localparam int INST_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int IMEM_BYTES_DEF = 32;

    // Fetch controller states. The top keeps its state register as plain
    // logic and names the encodings through localparams built from these.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_pkt_t;

    // A redirect target is unusable when it is not word aligned or points
    // past the last whole word of instruction memory.
    function automatic logic target_illegal(input logic [ADDR_W-1:0] target,
                                            input logic [ADDR_W-1:0] last_addr);
        return (target[1:0] != 2'b00) || (target > last_addr);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Output holding register between fetch and decode.
//
// Handshake: a packet is transferred on a rising edge where valid && ready.
// While valid is high and ready is low, dout and valid are held stable.
// flush drops the held packet regardless of ready; load captures a new
// packet and has priority over the drain that a completed handshake causes.
module fetch_buffer
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       flush,
    input  logic       ready,
    input  fetch_pkt_t din,
    output logic       valid,
    output fetch_pkt_t dout
);

    // Valid flag: flush beats load, load beats drain-on-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Payload: captured only on load, otherwise held so decode sees stable data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (load && !flush) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM and delivered-instruction
// counter, driving inst_memory and feeding decode through fetch_buffer.
module fetch_unit
    import risc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                IMEM_BYTES = IMEM_BYTES_DEF,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] im_addr,
    output logic              en_im,
    input  logic [INST_W-1:0] im_inst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              id_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              done,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 4);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              running;
    logic              load;
    logic              pc_in_range;
    logic              tgt_bad;
    logic              do_fetch;
    logic              do_end;
    logic              do_redirect;
    logic              buf_flush;
    fetch_pkt_t        buf_din;
    fetch_pkt_t        buf_dout;

    // Fetch decision for this cycle. A redirect overrides both stall and
    // end-of-program; the output register may only be reloaded when it is
    // empty or its current word is being taken by decode.
    always_comb begin
        running     = (state == ST_RUN);
        load        = !inst_valid || id_ready;
        pc_in_range = (pc <= LAST_ADDR);
        tgt_bad     = target_illegal(branch_target, LAST_ADDR);
        do_redirect = running && branch_taken;
        do_fetch    = running && !branch_taken && load && pc_in_range;
        do_end      = running && !branch_taken && load && !pc_in_range;
        buf_flush   = do_redirect || do_end;
    end

    assign im_addr   = pc;
    assign en_im     = do_fetch;
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    assign buf_din.inst = im_inst;
    assign buf_din.pc   = pc;

    // Next-state logic; DONE is only left through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (do_redirect) begin
                    if (tgt_bad) begin
                        state_nxt = ST_DONE;
                    end
                end else if (do_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC: loaded on start, advanced per fetch, replaced by a legal redirect.
    // An illegal redirect leaves it where it was so the faulting point is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (state == ST_IDLE) begin
            if (start) begin
                pc <= RESET_PC;
            end
        end else if (do_redirect) begin
            if (!tgt_bad) begin
                pc <= branch_target;
            end
        end else if (do_fetch) begin
            pc <= pc + 32'd4;
        end
    end

    // Sticky error flag for an illegal redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (do_redirect && tgt_bad) begin
            fetch_err <= 1'b1;
        end
    end

    // Delivered-instruction counter; a handshake in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (inst_valid && id_ready) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (do_fetch),
        .flush (buf_flush),
        .ready (id_ready),
        .din   (buf_din),
        .valid (inst_valid),
        .dout  (buf_dout)
    );

    assign inst_out = buf_dout.inst;
    assign pc_out   = buf_dout.pc;

endmodule
